register_file_unit: RTL
=======================

// Module: register_file_unit
// PURPOSE
//  Upstream operand stage for functionUnit: register file that drives its A and B buses.
//  Writes back either the function-unit result or external data into one destination register.
//  Latches the V/C/Z/N flags into a status register.
//  After reset it runs a self-clearing sweep that zeroes every register before accepting writes.
// PARAMETERS
//  WIDTH   16  data/register width (matches functionUnit A, B and data)
//  ADDR_W  3   register address width; DEPTH = 2**ADDR_W registers (8)
// PORTS
//  clock     in   1       single clock; all state updates on posedge
//  reset     in   1       synchronous, active-high reset
//  AA        in   ADDR_W  A-bus read address
//  BA        in   ADDR_W  B-bus read address
//  DA        in   ADDR_W  destination (write) address
//  RW        in   1       register write enable
//  MB        in   1       B-bus select: 0 = reg[BA], 1 = const_in
//  const_in  in   WIDTH   constant operand for B bus
//  MD        in   1       write-data select: 0 = fu_data, 1 = data_in
//  fu_data   in   WIDTH   result from functionUnit data output
//  data_in   in   WIDTH   external/memory write data
//  V,C,Z,N   in   1 each  flags from functionUnit (functionUnit's Zr drives Z)
//  FL        in   1       flag load enable
//  A_bus     out  WIDTH   operand A to functionUnit
//  B_bus     out  WIDTH   operand B to functionUnit
//  status    out  4       latched flags {V,C,Z,N}
//  ready     out  1       1 = RUN state, writes accepted
// BEHAVIOUR
//  - FSM with two states: CLEAR and RUN.
//  - reset=1 at a posedge:
//    - state <= CLEAR, clr_cnt <= 0, status <= 4'b0000, ready <= 0.
//    - Applies from any state, including mid-sweep; the sweep restarts from reg 0.
//  - CLEAR state:
//    - Each cycle: reg[clr_cnt] <= 0, clr_cnt <= clr_cnt+1.
//    - After writing reg[DEPTH-1]: state <= RUN, ready <= 1.
//    - Sweep takes exactly DEPTH cycles after reset deasserts; ready rises on the DEPTH-th posedge.
//    - RW and FL are ignored, and status holds 0.
//    - A_bus and B_bus are forced to 0 (MB is still honoured: MB=1 gives const_in).
//  - RUN state:
//    - RW=1: reg[DA] <= (MD ? data_in : fu_data) at posedge.
//    - All registers, including reg 0, are writable.
//    - FL=1: status <= {V,C,Z,N} at posedge; FL=0 holds status.
//  - Reads:
//    - A_bus = reg[AA] combinationally.
//    - B_bus = MB ? const_in : reg[BA].
//    - No write bypass: a read of DA in the cycle it is written returns the old value.
//    - The new value is visible after the posedge.
//    - No bypass is mandatory: fu_data depends on A_bus/B_bus, so a bypass would form a combinational loop.
//  - Simultaneous events:
//    - AA == BA == DA with RW=1: both buses show the old value; one write occurs.
//    - RW and FL in the same cycle: both take effect.
//    - reset overrides RW and FL.
//  - Widths:
//    - All data is WIDTH bits with no extension or truncation.
//    - clr_cnt is ADDR_W bits; its wrap to 0 coincides with the CLEAR->RUN exit.
//  - Latency: write-to-read 1 cycle; flag-to-status 1 cycle; reset-to-ready DEPTH cycles.
// TESTING
//  1 Reset sweep:
//    - Preload regs with nonzero values, assert reset for 1 cycle, hold RW=1 with data_in=16'hFFFF, MD=1.
//    - Required: ready=0 for 8 cycles, then 1; every reg reads 0; status=0.
//  2 Write/read both paths:
//    - RW=1, DA=3, MD=0, fu_data=16'd26 -> A_bus(AA=3)=26 next cycle.
//    - DA=5, MD=1, data_in=16'h8000 -> B_bus(BA=5,MB=0)=16'h8000.
//  3 No-bypass:
//    - AA=BA=DA=2, reg2=15, RW=1, fu_data=16'd16.
//    - Required: A_bus=B_bus=15 in the write cycle and 16 after the posedge.
//  4 Constant/flags:
//    - MB=1, const_in=16'd11 -> B_bus=11 regardless of BA.
//    - FL=1 with V=1,C=0,Z=0,N=1 -> status=4'b1001.
//    - FL=0 with flags changed -> status holds 4'b1001.
//  5 Reset mid-sweep:
//    - Reassert reset at sweep cycle 4 -> clr_cnt restarts at 0; ready rises 8 cycles after the second reset.
//  6 Closed loop with functionUnit:
//    - reg1=15, reg2=11, S=4'b0010, AA=1, BA=2, DA=3, RW=1, FL=1.
//    - Required: reg3=26 and status=4'b0000.
//    - Then reg1=32760 with the same operation -> reg3=32771 and status V=1, N=1.

Source files
------------

// File: rtl/register_file_unit.sv
// Operand register file feeding functionUnit: two read buses, one write port, latched flags.
// After reset a sweep zeroes every register before normal writes are accepted.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   CLEAR | zeroing reg[clr_cnt] each cycle; RW/FL ignored; buses forced 0
//   RUN   | normal operation; RW writes reg[DA], FL loads status
module register_file_unit #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    input  logic [ADDR_W-1:0] DA,
    input  logic              RW,
    input  logic              MB,
    input  logic [WIDTH-1:0]  const_in,
    input  logic              MD,
    input  logic [WIDTH-1:0]  fu_data,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              V,
    input  logic              C,
    input  logic              Z,
    input  logic              N,
    input  logic              FL,
    output logic [WIDTH-1:0]  A_bus,
    output logic [WIDTH-1:0]  B_bus,
    output logic [3:0]        status,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [WIDTH-1:0]  regs [DEPTH];

    // The register array has no reset of its own; the sweep is what clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            status  <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    regs[clr_cnt] <= '0;
                    clr_cnt       <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (RW)
                        regs[DA] <= MD ? data_in : fu_data;
                    if (FL)
                        status <= {V, C, Z, N};
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // No write bypass: fu_data is a function of these buses, so bypassing would loop.
    always_comb begin
        A_bus = '0;
        B_bus = '0;
        if (state == RUN) begin
            A_bus = regs[AA];
            B_bus = regs[BA];
        end
        if (MB)
            B_bus = const_in;
    end

endmodule
